// File: rtl/handshake_constant_arbiter.sv
// ---------------------------------------------------------------------------
// handshake_constant_arbiter
//
// Shares one registered constant-issuing output channel between NUM_REQ
// control-token requesters. Each accepted token from requester i produces
// CONST_TABLE[i] on outs one cycle later. Arbitration is round-robin,
// starting the scan at the requester after the most recently served one.
//
// Optional feature macro: HANDSHAKE_CONST_ARB_ID_OUT_EN
//   When defined, adds outs_id carrying the index of the requester whose
//   constant currently sits in the output slot.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-low reset (0 = reset asserted)
//   ctrl_valid  per-requester control token valid      [NUM_REQ]
//   ctrl_ready  per-requester ready, at most one high   [NUM_REQ]
//   outs        registered constant                     [DATA_WIDTH]
//   outs_valid  output token valid (slot FULL)
//   outs_ready  consumer ready
//   outs_id     index of the served requester (macro only) [ID_WIDTH]
// ---------------------------------------------------------------------------
module handshake_constant_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 2,
  // Entry i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]; entry 0 is 0x0DFD.
  parameter logic [NUM_REQ*DATA_WIDTH-1:0] CONST_TABLE =
    {32'h0000_0011, 32'h0000_0033, 32'h0000_0044, 32'h0000_0DFD}
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    ctrl_valid,
  output logic [NUM_REQ-1:0]    ctrl_ready,
  output logic [DATA_WIDTH-1:0] outs,
  output logic                  outs_valid,
`ifdef HANDSHAKE_CONST_ARB_ID_OUT_EN
  output logic [ID_WIDTH-1:0]   outs_id,
`endif
  input  logic                  outs_ready
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_state_t;

  slot_state_t           state_reg, state_next;
  logic [ID_WIDTH-1:0]   prio_reg;
  logic [DATA_WIDTH-1:0] outs_reg;

  logic [DATA_WIDTH-1:0] const_arr [NUM_REQ];
  logic [ID_WIDTH-1:0]   grant_idx;
  logic                  grant_any;
  logic                  load;
  logic                  transfer;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_const
      assign const_arr[gi] = CONST_TABLE[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // Slot can accept a new constant when empty or when it drains this cycle.
  assign load = (state_reg == EMPTY) || outs_ready;

  // Round-robin scan starting at prio_reg, wrapping modulo NUM_REQ.
  always_comb begin
    int idx;
    grant_any = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(prio_reg) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grant_any && ctrl_valid[ID_WIDTH'(idx)]) begin
        grant_any = 1'b1;
        grant_idx = ID_WIDTH'(idx);
      end
    end
  end

  // Ready is forced low while reset is asserted so nothing is accepted
  // from an upstream that is itself being reset.
  assign transfer   = grant_any && load && rst;
  assign ctrl_ready = transfer ? (NUM_REQ'(1) << grant_idx) : '0;

  always_comb begin
    state_next = state_reg;
    if (transfer) begin
      state_next = FULL;
    end else if (state_reg == FULL && outs_ready) begin
      state_next = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  // Data and pointer only move on a transfer, so a drain leaves outs stable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outs_reg <= '0;
      prio_reg <= '0;
    end else if (transfer) begin
      outs_reg <= const_arr[grant_idx];
      prio_reg <= (grant_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

`ifdef HANDSHAKE_CONST_ARB_ID_OUT_EN
  logic [ID_WIDTH-1:0] id_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_reg <= '0;
    end else if (transfer) begin
      id_reg <= grant_idx;
    end
  end

  assign outs_id = id_reg;
`endif

  assign outs       = outs_reg;
  assign outs_valid = (state_reg == FULL);

endmodule
